// File: rtl/div4_seq.sv
// Sequential restoring divider: one quotient bit per clock through a single (WIDTH+1)-bit
// subtractor using the A + ~B + 1 convention. Start/done handshake, registered outputs.
module div4_seq #(
    parameter int unsigned WIDTH = 4
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             start,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    output logic [WIDTH-1:0] Q,
    output logic [WIDTH-1:0] R,
    output logic             busy,
    output logic             done,
    output logic             div_zero
);

    localparam int unsigned CntW = (WIDTH > 2) ? $clog2(WIDTH) : 1;
    localparam logic [CntW-1:0] CntLast = CntW'(WIDTH - 1);
    localparam logic [WIDTH:0] RemOne = {{WIDTH{1'b0}}, 1'b1};

    typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

    state_e           state_q, state_d;
    logic [WIDTH:0]   rem_q, rem_d;
    logic [WIDTH-1:0] dvd_q, dvd_d;
    logic [WIDTH-1:0] dvs_q, dvs_d;
    logic [WIDTH-1:0] quo_q, quo_d;
    logic [CntW-1:0]  cnt_q, cnt_d;
    logic [WIDTH-1:0] q_q, q_d;
    logic [WIDTH-1:0] r_q, r_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             div_zero_q, div_zero_d;

    logic [WIDTH:0]   rem_shift;
    logic [WIDTH:0]   trial;
    logic             fits;

    // Shared datapath: shift in the dividend MSB, then trial-subtract the divisor.
    always_comb begin
        rem_shift = (rem_q << 1) | {{WIDTH{1'b0}}, dvd_q[WIDTH-1]};
        trial     = rem_shift + ~{1'b0, dvs_q} + RemOne;
        fits      = ~trial[WIDTH];
    end

    always_comb begin
        state_d    = state_q;
        rem_d      = rem_q;
        dvd_d      = dvd_q;
        dvs_d      = dvs_q;
        quo_d      = quo_q;
        cnt_d      = cnt_q;
        q_d        = q_q;
        r_d        = r_q;
        busy_d     = busy_q;
        done_d     = 1'b0;
        div_zero_d = div_zero_q;

        unique case (state_q)
            StIdle, StDone: begin
                state_d = StIdle;
                if (start) begin
                    dvd_d = A;
                    dvs_d = B;
                    rem_d = '0;
                    quo_d = '0;
                    cnt_d = '0;
                    if (B != '0) begin
                        state_d    = StRun;
                        busy_d     = 1'b1;
                        div_zero_d = 1'b0;
                    end else begin
                        // Divide by zero short-circuits straight to a result.
                        state_d    = StDone;
                        done_d     = 1'b1;
                        q_d        = '1;
                        r_d        = A;
                        div_zero_d = 1'b1;
                    end
                end
            end
            StRun: begin
                rem_d = fits ? trial : rem_shift;
                dvd_d = dvd_q << 1;
                quo_d = {quo_q[WIDTH-2:0], fits};
                cnt_d = cnt_q + CntW'(1);
                if (cnt_q == CntLast) begin
                    state_d    = StDone;
                    busy_d     = 1'b0;
                    done_d     = 1'b1;
                    q_d        = quo_d;
                    r_d        = rem_d[WIDTH-1:0];
                    div_zero_d = 1'b0;
                end
            end
            default: begin
                state_d = StIdle;
                busy_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q    <= StIdle;
            rem_q      <= '0;
            dvd_q      <= '0;
            dvs_q      <= '0;
            quo_q      <= '0;
            cnt_q      <= '0;
            q_q        <= '0;
            r_q        <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            div_zero_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            rem_q      <= rem_d;
            dvd_q      <= dvd_d;
            dvs_q      <= dvs_d;
            quo_q      <= quo_d;
            cnt_q      <= cnt_d;
            q_q        <= q_d;
            r_q        <= r_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            div_zero_q <= div_zero_d;
        end
    end

    assign Q        = q_q;
    assign R        = r_q;
    assign busy     = busy_q;
    assign done     = done_q;
    assign div_zero = div_zero_q;

endmodule

// File: tb/tb_div4_seq.sv
// Bench for div4_seq: scoreboard of expected quotient/remainder pushed at acceptance,
// popped and compared when done is observed.
module tb_div4_seq;

    localparam int W = 4;

    typedef struct {
        logic [W-1:0] q;
        logic [W-1:0] r;
        logic         dz;
    } exp_t;

    logic         clk;
    logic         reset_n;
    logic         start;
    logic [W-1:0] a_in;
    logic [W-1:0] b_in;
    logic [W-1:0] q_out;
    logic [W-1:0] r_out;
    logic         busy;
    logic         done;
    logic         div_zero;

    exp_t sb[$];
    int   n_tests;
    int   n_fail;

    div4_seq #(.WIDTH(W)) dut (
        .clk      (clk),
        .reset_n  (reset_n),
        .start    (start),
        .A        (a_in),
        .B        (b_in),
        .Q        (q_out),
        .R        (r_out),
        .busy     (busy),
        .done     (done),
        .div_zero (div_zero)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic exp_t model(input logic [W-1:0] a, input logic [W-1:0] b);
        exp_t e;
        if (b == 0) begin
            e.q  = '1;
            e.r  = a;
            e.dz = 1'b1;
        end else begin
            e.q  = a / b;
            e.r  = a % b;
            e.dz = 1'b0;
        end
        return e;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Drives one accepting edge; returns sampled just after it.
    task automatic start_op(input logic [W-1:0] a, input logic [W-1:0] b, input bit push,
                            input bit keep);
        a_in  = a;
        b_in  = b;
        start = 1'b1;
        if (push) sb.push_back(model(a, b));
        tick();
        if (!keep) start = 1'b0;
        a_in = ~a;
        b_in = b + 4'd5;
    endtask

    task automatic wait_done(input int budget, output bit got, output int lat, output int bc);
        got = 1'b0;
        lat = 0;
        bc  = 0;
        for (int i = 0; i < budget; i++) begin
            if (done) begin
                got   = 1'b1;
                lat   = i;
                start = 1'b0;
                break;
            end
            if (busy) bc++;
            tick();
        end
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        start   = 1'b1;
        a_in    = 4'd5;
        b_in    = 4'd2;
        tick();
        tick();
        n_tests++;
        if ({q_out, r_out, busy, done, div_zero} !== 11'd0) begin
            n_fail++;
            $display("FAIL reset_outputs: got Q=%0d R=%0d busy=%b done=%b dz=%b, want all 0",
                     q_out, r_out, busy, done, div_zero);
        end
        start   = 1'b0;
        reset_n = 1'b1;
        tick();
    endtask

    task automatic test_normal();
        bit   got;
        int   lat;
        int   bc;
        int   bad;
        exp_t e;
        start_op(4'd13, 4'd3, 1'b1, 1'b0);
        n_tests++;
        if (busy !== 1'b1 || done !== 1'b0 || q_out !== 4'd0) begin
            n_fail++;
            $display("FAIL normal_accept: got busy=%b done=%b Q=%0d, want busy=1 done=0 Q=0",
                     busy, done, q_out);
        end
        wait_done(20, got, lat, bc);
        e = sb.pop_front();
        n_tests++;
        if (!got || lat != W || bc != W) begin
            n_fail++;
            $display("FAIL normal_timing: got done=%b lat=%0d busy_cycles=%0d, want 1/%0d/%0d",
                     got, lat, bc, W, W);
        end
        n_tests++;
        if (q_out !== e.q || r_out !== e.r || div_zero !== e.dz || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL normal_result: got Q=%0d R=%0d dz=%b busy=%b, want Q=%0d R=%0d dz=%b",
                     q_out, r_out, div_zero, busy, e.q, e.r, e.dz);
        end
        bad = 0;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (q_out !== 4'd4 || r_out !== 4'd1 || done !== 1'b0 || busy !== 1'b0) bad++;
        end
        n_tests++;
        if (bad != 0) begin
            n_fail++;
            $display("FAIL normal_hold: got %0d bad idle cycles (Q=%0d R=%0d), want 0 (Q=4 R=1)",
                     bad, q_out, r_out);
        end
    endtask

    task automatic test_div_zero();
        bit   got;
        int   lat;
        int   bc;
        exp_t e;
        start_op(4'd9, 4'd0, 1'b1, 1'b0);
        wait_done(20, got, lat, bc);
        e = sb.pop_front();
        n_tests++;
        if (!got || lat != 0 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL dz_timing: got done=%b lat=%0d busy=%b, want 1/0/0", got, lat, busy);
        end
        n_tests++;
        if (q_out !== e.q || r_out !== e.r || div_zero !== e.dz) begin
            n_fail++;
            $display("FAIL dz_result: got Q=%0d R=%0d dz=%b, want Q=%0d R=%0d dz=%b",
                     q_out, r_out, div_zero, e.q, e.r, e.dz);
        end
        tick();
        n_tests++;
        if (done !== 1'b0 || busy !== 1'b0 || div_zero !== 1'b1 || q_out !== 4'd15) begin
            n_fail++;
            $display("FAIL dz_pulse: got done=%b busy=%b dz=%b Q=%0d, want 0/0/1/15",
                     done, busy, div_zero, q_out);
        end
    endtask

    task automatic test_edge_operands();
        logic [W-1:0] ta[3] = '{4'd15, 4'd2, 4'd0};
        logic [W-1:0] tb[3] = '{4'd1, 4'd7, 4'd5};
        bit   got;
        int   lat;
        int   bc;
        exp_t e;
        for (int i = 0; i < 3; i++) begin
            start_op(ta[i], tb[i], 1'b1, 1'b0);
            if (i == 0) begin
                n_tests++;
                if (div_zero !== 1'b0) begin
                    n_fail++;
                    $display("FAIL dz_clear: got dz=%b after new start, want 0", div_zero);
                end
            end
            wait_done(20, got, lat, bc);
            e = sb.pop_front();
            n_tests++;
            if (!got || q_out !== e.q || r_out !== e.r || div_zero !== e.dz) begin
                n_fail++;
                $display("FAIL edge_%0d_%0d: got done=%b Q=%0d R=%0d, want Q=%0d R=%0d",
                         ta[i], tb[i], got, q_out, r_out, e.q, e.r);
            end
        end
        tick();
    endtask

    task automatic test_hold_start();
        bit   got;
        int   lat;
        int   bc;
        exp_t e;
        start_op(4'd11, 4'd2, 1'b1, 1'b1);
        wait_done(20, got, lat, bc);
        e = sb.pop_front();
        n_tests++;
        if (!got || lat != W || q_out !== e.q || r_out !== e.r) begin
            n_fail++;
            $display("FAIL hold_start: got done=%b lat=%0d Q=%0d R=%0d, want 1/%0d Q=%0d R=%0d",
                     got, lat, q_out, r_out, W, e.q, e.r);
        end
        tick();
        n_tests++;
        if (busy !== 1'b0 || done !== 1'b0) begin
            n_fail++;
            $display("FAIL hold_idle: got busy=%b done=%b, want 0/0", busy, done);
        end
    endtask

    task automatic test_back_to_back();
        bit   got;
        int   lat;
        int   bc;
        exp_t e;
        start_op(4'd14, 4'd3, 1'b1, 1'b0);
        wait_done(20, got, lat, bc);
        e = sb.pop_front();
        n_tests++;
        if (!got || q_out !== e.q || r_out !== e.r) begin
            n_fail++;
            $display("FAIL b2b_first: got done=%b Q=%0d R=%0d, want Q=%0d R=%0d",
                     got, q_out, r_out, e.q, e.r);
        end
        start_op(4'd10, 4'd4, 1'b1, 1'b0);
        n_tests++;
        if (busy !== 1'b1 || done !== 1'b0 || q_out !== 4'd4 || r_out !== 4'd2) begin
            n_fail++;
            $display("FAIL b2b_accept: got busy=%b done=%b Q=%0d R=%0d, want 1/0 Q=4 R=2",
                     busy, done, q_out, r_out);
        end
        wait_done(20, got, lat, bc);
        e = sb.pop_front();
        n_tests++;
        if (!got || bc != W || q_out !== e.q || r_out !== e.r || div_zero !== 1'b0) begin
            n_fail++;
            $display("FAIL b2b_second: got done=%b busy_cycles=%0d Q=%0d R=%0d, want Q=%0d R=%0d",
                     got, bc, q_out, r_out, e.q, e.r);
        end
        tick();
    endtask

    task automatic test_abort();
        int seen;
        start_op(4'd13, 4'd3, 1'b0, 1'b0);
        tick();
        reset_n = 1'b0;
        tick();
        reset_n = 1'b1;
        n_tests++;
        if ({q_out, r_out, busy, done, div_zero} !== 11'd0) begin
            n_fail++;
            $display("FAIL abort_reset: got Q=%0d R=%0d busy=%b done=%b dz=%b, want all 0",
                     q_out, r_out, busy, done, div_zero);
        end
        seen = 0;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (done || busy) seen++;
        end
        n_tests++;
        if (seen != 0) begin
            n_fail++;
            $display("FAIL abort_no_done: got %0d cycles with done/busy, want 0", seen);
        end
    endtask

    task automatic test_exhaustive();
        bit   got;
        int   lat;
        int   bc;
        int   bad;
        exp_t e;
        bad = 0;
        for (int a = 0; a < 16; a++) begin
            for (int b = 0; b < 16; b++) begin
                start_op(4'(a), 4'(b), 1'b1, 1'b0);
                wait_done(20, got, lat, bc);
                e = sb.pop_front();
                if (!got || q_out !== e.q || r_out !== e.r || div_zero !== e.dz ||
                    (div_zero !== (b == 0)) ||
                    (b != 0 && (a != int'(q_out) * b + int'(r_out) || int'(r_out) >= b))) begin
                    bad++;
                    if (bad <= 4)
                        $display("FAIL sweep_%0d_%0d: got done=%b Q=%0d R=%0d dz=%b, want Q=%0d R=%0d dz=%b",
                                 a, b, got, q_out, r_out, div_zero, e.q, e.r, e.dz);
                end
            end
        end
        n_tests++;
        if (bad != 0) begin
            n_fail++;
            $display("FAIL sweep_total: got %0d bad pairs, want 0", bad);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got simulation still running, want finished");
        $fatal(1, "watchdog");
    end

    initial begin
        n_tests = 0;
        n_fail  = 0;
        start   = 1'b0;
        a_in    = '0;
        b_in    = '0;
        reset_n = 1'b0;
        test_reset();
        test_normal();
        test_div_zero();
        test_edge_operands();
        test_hold_start();
        test_back_to_back();
        test_abort();
        test_exhaustive();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
